irq_ctrl: RTL and testbench
===========================

# irq_ctrl

Machine-mode interrupt controller for the RV32I core; it sits on the opposite side of the `mip` CSR from the CSR file. It synchronises the hardware interrupt lines (external, timer, software) and owns every write into the `mip` storage register, merging CSR-instruction writes with hardware pending levels. It reads back `mip`/`mie`/`mstatus.MIE`, arbitrates by RISC-V priority and drives a request/acknowledge handshake to the pipeline's trap unit.

## Interface
- No parameters.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- ext_irq  in  1  external interrupt level (MEIP source); asynchronous to clk.
- timer_irq  in  1  timer interrupt level (MTIP source).
- soft_irq  in  1  software interrupt level (MSIP source).
- csr_mip_we  in  1  CSR instruction writes `mip` this cycle.
- csr_mip_wdata  in  32  CSR write data for `mip`.
- mip  in  32  current `mip` register value, read back.
- mie  in  32  current `mie` register value.
- mstatus_mie  in  1  global machine interrupt enable.
- irq_ack  in  1  trap unit accepts the request; valid only while irq_req=1.
- mip_in  out  32  next `mip` value to the storage register.
- wr_mip  out  1  write strobe to the storage register.
- irq_req  out  1  interrupt trap request.
- irq_cause  out  32  `mcause` value for the request; bit 31 = 1.

## Operation
- Hardware-owned bits: 11 (MEIP), 7 (MTIP), 3 (MSIP). CSR writes never change them; they always take the synchronised level of ext_irq/timer_irq/soft_irq. The hw level vector is h.
- Legal pending bits: 11, 9, 8, 7, 5, 4, 3, 1, 0. All other bits of mip_in are 0.
- Write path (registered): when csr_mip_we=1, mip_in = csr_mip_wdata legal bits with 11/7/3 replaced by h. Otherwise, when any h bit differs from the corresponding mip bit, mip_in = mip with 11/7/3 replaced by h. wr_mip=1 for exactly that cycle. If neither condition holds, wr_mip=0 and mip_in holds its previous value.
- Pending set p = mip & mie & legal mask.
- Priority and code (irq_cause[4:0]): MEI 11 > MSI 3 > MTI 7 > SEI 9 > SSI 1 > STI 5 > UEI 8 > USI 0. irq_cause[30:5] = 0.
- FSM:
  - IDLE: if mstatus_mie=1 and p≠0, latch the cause of the highest-priority pending bit, go to REQ.
  - REQ: irq_req=1, irq_cause held stable. On irq_ack=1, go to WAIT. Otherwise, if mstatus_mie=0 or the latched bit is no longer in p, withdraw and return to IDLE. When ack and withdraw coincide, ack wins.
  - WAIT: irq_req=0. Remain until mstatus_mie=0 is observed (trap entry cleared it), then go to IDLE. This prevents a duplicate request before MIE drops.
- While in REQ, a newly pending higher-priority interrupt does not replace the latched cause.

## Timing
- Reset values: mip_in=0, wr_mip=0, irq_req=0, irq_cause=0, FSM=IDLE, synchroniser flops=0.
- Input change → h: 2 clk (with sync) or 1 clk (without).
- h change → wr_mip/mip_in: +1 clk. `mip` updates at the following edge.
- p≠0 with mstatus_mie=1 in IDLE → irq_req=1 on the next edge, so irq_req is registered.
- irq_ack sampled at the edge → irq_req=0 in the following cycle.
- Reset asserted mid-handshake: all state clears immediately. No request is replayed.

## Configuration
- IRQ_CTRL_SYNC_EN defined: each of ext_irq/timer_irq/soft_irq passes through a 2-flop synchroniser.
- IRQ_CTRL_SYNC_EN undefined: the inputs are synchronous to clk and go through a single register stage, giving 1-cycle-lower latency.

## Structure
- Shared CSR package: mip/mie bit-index constants, the legal-bit mask, the hw-owned mask, the interrupt cause codes, and the FSM state enum.
- One sub-module, `irq_sync`: a single-bit synchroniser whose depth is selected by IRQ_CTRL_SYNC_EN. It is instantiated three times.

## Test plan
- Reset: assert rst_n=0 mid-REQ → all outputs 0 next cycle; after release, FSM=IDLE and no request.
- ext_irq 0→1 with mie[11]=1, mstatus_mie=1, mip echoed from a model register → wr_mip pulse with mip_in=0x800; irq_req=1 with irq_cause=0x8000000B; irq_ack → irq_req=0; WAIT until mstatus_mie=0.
- CSR write csr_mip_wdata=0xFFFFFFFF with all hw levels 0 → mip_in=0x00000333 (11/7/3 forced to 0).
- timer_irq and soft_irq rise in the same cycle with mie=0x88 → irq_cause=0x80000003 (MSI beats MTI).
- REQ withdraw: raise timer_irq, then drop mstatus_mie before ack → irq_req falls next cycle, FSM=IDLE; repeat with ack in the same cycle → FSM=WAIT.
- MIE still 1 after ack: hold mstatus_mie=1 for 5 cycles → no second irq_req; drop then re-raise MIE → new request.

Source files
------------

// File: rtl/irq_ctrl_pkg.sv
// Shared CSR definitions for the interrupt controller: mip/mie bit indices,
// which equal the mcause codes, the legal and hw-owned masks, and the FSM states.
package irq_ctrl_pkg;

    localparam int USI = 0;
    localparam int SSI = 1;
    localparam int MSI = 3;
    localparam int STI = 5;
    localparam int MTI = 7;
    localparam int UEI = 8;
    localparam int SEI = 9;
    localparam int MEI = 11;

    localparam logic [31:0] LEGAL_MASK  = 32'h0000_0BBB;
    localparam logic [31:0] HW_MASK     = 32'h0000_0888;
    // Bit 4 is storable but has no cause code, so it can never raise a request
    localparam logic [31:0] RANKED_MASK = 32'h0000_0BAB;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT
    } state_t;

    function automatic logic [4:0] top_cause(input logic [31:0] p);
        if (p[MEI])      return 5'(MEI);
        else if (p[MSI]) return 5'(MSI);
        else if (p[MTI]) return 5'(MTI);
        else if (p[SEI]) return 5'(SEI);
        else if (p[SSI]) return 5'(SSI);
        else if (p[STI]) return 5'(STI);
        else if (p[UEI]) return 5'(UEI);
        else             return 5'(USI);
    endfunction

endpackage

// File: rtl/irq_ctrl_if.sv
// CSR-file and trap-unit side of the interrupt controller; the controller is
// the master (drives the mip write port and the trap request).
interface irq_ctrl_if;
    logic        csr_mip_we;
    logic [31:0] csr_mip_wdata;
    logic [31:0] mip;
    logic [31:0] mie;
    logic        mstatus_mie;
    logic        irq_ack;
    logic [31:0] mip_in;
    logic        wr_mip;
    logic        irq_req;
    logic [31:0] irq_cause;

    modport master (
        input  csr_mip_we, csr_mip_wdata, mip, mie, mstatus_mie, irq_ack,
        output mip_in, wr_mip, irq_req, irq_cause
    );

    modport slave (
        output csr_mip_we, csr_mip_wdata, mip, mie, mstatus_mie, irq_ack,
        input  mip_in, wr_mip, irq_req, irq_cause
    );
endinterface

// File: rtl/irq_sync.sv
// Single-bit input stage for the hardware interrupt lines: two flops when
// IRQ_CTRL_SYNC_EN is defined (asynchronous sources), otherwise one register.
module irq_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

`ifdef IRQ_CTRL_SYNC_EN
    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q <= 1'b0;
        else        q <= d;
    end
`endif

endmodule

// File: rtl/irq_ctrl.sv
// Machine-mode interrupt controller: owns mip writes, arbitrates pending
// interrupts and handshakes with the trap unit. Input sync depth: IRQ_CTRL_SYNC_EN.
module irq_ctrl
    import irq_ctrl_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ext_irq,
    input  logic          timer_irq,
    input  logic          soft_irq,
    irq_ctrl_if.master    bus
);

    logic        h_ext, h_tmr, h_sft;
    logic [31:0] hw_vec;
    logic [31:0] mip_cur;
    logic [31:0] mip_next;
    logic        hw_diff;
    logic        do_wr;

    irq_sync u_sync_ext (.clk(clk), .rst_n(rst_n), .d(ext_irq),   .q(h_ext));
    irq_sync u_sync_tmr (.clk(clk), .rst_n(rst_n), .d(timer_irq), .q(h_tmr));
    irq_sync u_sync_sft (.clk(clk), .rst_n(rst_n), .d(soft_irq),  .q(h_sft));

    // A write already in flight is what mip will hold next; comparing against it
    // keeps wr_mip to a single pulse per change.
    always_comb begin
        hw_vec      = '0;
        hw_vec[MEI] = h_ext;
        hw_vec[MTI] = h_tmr;
        hw_vec[MSI] = h_sft;
        mip_cur     = bus.wr_mip ? bus.mip_in : bus.mip;
        hw_diff     = |((mip_cur ^ hw_vec) & HW_MASK);
        do_wr       = bus.csr_mip_we | hw_diff;
        mip_next    = ((bus.csr_mip_we ? bus.csr_mip_wdata : mip_cur)
                       & LEGAL_MASK & ~HW_MASK) | hw_vec;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.mip_in <= '0;
            bus.wr_mip <= 1'b0;
        end else begin
            bus.wr_mip <= do_wr;
            if (do_wr) bus.mip_in <= mip_next;
        end
    end

    state_t      state_q, state_d;
    logic [4:0]  code_q, code_d;
    logic        cause_v_q, cause_v_d;
    logic [31:0] pend;

    always_comb begin
        pend      = bus.mip & bus.mie & LEGAL_MASK;
        state_d   = state_q;
        code_d    = code_q;
        cause_v_d = cause_v_q;
        case (state_q)
            S_IDLE: begin
                if (bus.mstatus_mie && |(pend & RANKED_MASK)) begin
                    state_d   = S_REQ;
                    code_d    = top_cause(pend);
                    cause_v_d = 1'b1;
                end
            end
            S_REQ: begin
                if (bus.irq_ack)
                    state_d = S_WAIT;
                else if (!bus.mstatus_mie || !pend[code_q])
                    state_d = S_IDLE;
            end
            S_WAIT: begin
                if (!bus.mstatus_mie) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            code_q    <= '0;
            cause_v_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            cause_v_q <= cause_v_d;
        end
    end

    assign bus.irq_req   = (state_q == S_REQ);
    assign bus.irq_cause = {cause_v_q, 26'b0, code_q};

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: reference model checked every cycle, a vector table for
// write-path/priority cases, and hand-written handshake and reset sequences.
module tb_irq_ctrl;

`ifdef IRQ_CTRL_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ext_irq = 1'b0, timer_irq = 1'b0, soft_irq = 1'b0;

    irq_ctrl_if bus ();

    irq_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ext_irq   (ext_irq),
        .timer_irq (timer_irq),
        .soft_irq  (soft_irq),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    // The mip storage register this controller feeds
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          bus.mip <= '0;
        else if (bus.wr_mip) bus.mip <= bus.mip_in;
    end

    int n_vec = 0;
    int n_bad = 0;

    bit [2:0]  hist [2];
    bit [2:0]  n_hist [2];
    bit [31:0] m_mip_in, n_mip_in, m_cause, n_cause;
    bit        m_wr, n_wr, m_req, n_req, m_wait, n_wait;
    int        prio [8] = '{11, 3, 7, 9, 1, 5, 8, 0};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit [31:0] merge(input bit [31:0] base, input bit [2:0] lv);
        return (base & 32'h333) | (lv[2] ? 32'h800 : 32'h0)
                                | (lv[1] ? 32'h080 : 32'h0)
                                | (lv[0] ? 32'h008 : 32'h0);
    endfunction

    task automatic model_reset();
        hist[0] = '0; hist[1] = '0;
        m_mip_in = '0; m_wr = 0; m_req = 0; m_wait = 0; m_cause = '0;
    endtask

    task automatic model_eval();
        bit [2:0]  h;
        bit [31:0] stored, p;
        bit        found;
        int        best;
        h      = hist[LAT-1];
        stored = m_wr ? m_mip_in : bus.mip;
        n_mip_in = m_mip_in;
        n_wr     = 0;
        if (bus.csr_mip_we) begin
            n_mip_in = merge(bus.csr_mip_wdata, h);
            n_wr     = 1;
        end else if (stored[11] != h[2] || stored[7] != h[1] || stored[3] != h[0]) begin
            n_mip_in = merge(stored, h);
            n_wr     = 1;
        end
        p = bus.mip & bus.mie & 32'hBBB;
        found = 0; best = 0;
        for (int i = 0; i < 8; i++)
            if (!found && p[prio[i]]) begin found = 1; best = prio[i]; end
        n_req = m_req; n_wait = m_wait; n_cause = m_cause;
        if (m_req) begin
            if (bus.irq_ack) begin n_req = 0; n_wait = 1; end
            else if (!bus.mstatus_mie || !p[m_cause[4:0]]) n_req = 0;
        end else if (m_wait) begin
            if (!bus.mstatus_mie) n_wait = 0;
        end else if (bus.mstatus_mie && found) begin
            n_req   = 1;
            n_cause = 32'h8000_0000 | 32'(best);
        end
        n_hist[0] = {ext_irq, timer_irq, soft_irq};
        n_hist[1] = hist[0];
    endtask

    task automatic step();
        model_eval();
        @(posedge clk);
        hist = n_hist;
        m_mip_in = n_mip_in; m_wr = n_wr; m_req = n_req; m_wait = n_wait; m_cause = n_cause;
        #1;
        chk("mdl_mip_in",    bus.mip_in,           m_mip_in);
        chk("mdl_wr_mip",    32'(bus.wr_mip),      32'(m_wr));
        chk("mdl_irq_req",   32'(bus.irq_req),     32'(m_req));
        chk("mdl_irq_cause", bus.irq_cause,        m_cause);
        @(negedge clk);
    endtask

    task automatic wait_req(input string nm);
        int c = 0;
        while (!bus.irq_req && c < 12) begin step(); c++; end
        chk(nm, 32'(bus.irq_req), 32'd1);
    endtask

    typedef struct {
        bit [2:0]  lv;
        bit [31:0] wdata;
        bit [31:0] mie;
        bit [31:0] exp_mip_in;
        bit [31:0] exp_cause;   // bit 31 clear: no request expected
    } vec_t;

    vec_t tbl [13];

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c;
        tbl[0]  = '{3'b000, 32'hFFFF_FFFF, 32'h000, 32'h333, 32'h0};
        tbl[1]  = '{3'b111, 32'hFFFF_FFFF, 32'h000, 32'hBBB, 32'h0};
        tbl[2]  = '{3'b010, 32'hAAAA_AAAA, 32'h000, 32'h2A2, 32'h0};
        tbl[3]  = '{3'b001, 32'h5555_5555, 32'h000, 32'h119, 32'h0};
        tbl[4]  = '{3'b011, 32'h0000_0000, 32'h088, 32'h088, 32'h8000_0003};
        tbl[5]  = '{3'b111, 32'h0000_0000, 32'hFFF, 32'h888, 32'h8000_000B};
        tbl[6]  = '{3'b010, 32'h0000_0333, 32'hFFF, 32'h3B3, 32'h8000_0007};
        tbl[7]  = '{3'b000, 32'h0000_0333, 32'h333, 32'h333, 32'h8000_0009};
        tbl[8]  = '{3'b000, 32'h0000_0133, 32'hFFF, 32'h133, 32'h8000_0001};
        tbl[9]  = '{3'b000, 32'h0000_0131, 32'hFFF, 32'h131, 32'h8000_0005};
        tbl[10] = '{3'b000, 32'h0000_0101, 32'hFFF, 32'h101, 32'h8000_0008};
        tbl[11] = '{3'b000, 32'h0000_0001, 32'hFFF, 32'h001, 32'h8000_0000};
        tbl[12] = '{3'b100, 32'h0000_0333, 32'h333, 32'hB33, 32'h8000_0009};

        bus.csr_mip_we = 0; bus.csr_mip_wdata = '0; bus.mie = '0;
        bus.mstatus_mie = 0; bus.irq_ack = 0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_mip_in",    bus.mip_in,       32'h0);
        chk("rst_wr_mip",    32'(bus.wr_mip),  32'h0);
        chk("rst_irq_req",   32'(bus.irq_req), 32'h0);
        chk("rst_irq_cause", bus.irq_cause,    32'h0);
        rst_n = 1;
        repeat (3) step();

        // Write path and priority table
        foreach (tbl[i]) begin
            {ext_irq, timer_irq, soft_irq} = tbl[i].lv;
            bus.mie = '0; bus.mstatus_mie = 0;
            repeat (LAT + 3) step();
            bus.csr_mip_we = 1; bus.csr_mip_wdata = tbl[i].wdata;
            step();
            bus.csr_mip_we = 0;
            chk("tbl_wr_mip", 32'(bus.wr_mip), 32'd1);
            chk("tbl_mip_in", bus.mip_in, tbl[i].exp_mip_in);
            repeat (2) step();
            bus.mie = tbl[i].mie; bus.mstatus_mie = 1;
            step();
            chk("tbl_req", 32'(bus.irq_req), 32'(tbl[i].exp_cause[31]));
            if (tbl[i].exp_cause[31]) chk("tbl_cause", bus.irq_cause, tbl[i].exp_cause);
            bus.irq_ack = bus.irq_req;
            step();
            bus.irq_ack = 0; bus.mstatus_mie = 0;
            step();
            bus.csr_mip_we = 1; bus.csr_mip_wdata = '0;
            step();
            bus.csr_mip_we = 0;
        end
        {ext_irq, timer_irq, soft_irq} = 3'b000;
        bus.mie = '0;
        repeat (LAT + 4) step();

        // External interrupt end to end, then no duplicate while MIE stays set
        bus.mie = 32'h800; bus.mstatus_mie = 1; ext_irq = 1;
        c = 0;
        do begin step(); c++; end while (!bus.wr_mip && c < 12);
        chk("ext_wr_lat", 32'(c), 32'(LAT + 1));
        chk("ext_mip_in", bus.mip_in, 32'h800);
        c = 0;
        do begin step(); c++; end while (!bus.irq_req && c < 12);
        chk("ext_req_lat", 32'(c), 32'd2);
        chk("ext_cause", bus.irq_cause, 32'h8000_000B);
        bus.irq_ack = 1;
        step();
        bus.irq_ack = 0;
        chk("ext_ack_drop", 32'(bus.irq_req), 32'd0);
        repeat (5) begin
            step();
            chk("ext_no_dup", 32'(bus.irq_req), 32'd0);
        end
        bus.mstatus_mie = 0; step();
        bus.mstatus_mie = 1; step();
        chk("ext_rereq", 32'(bus.irq_req), 32'd1);
        chk("ext_rereq_cause", bus.irq_cause, 32'h8000_000B);
        bus.irq_ack = 1; step();
        bus.irq_ack = 0; bus.mstatus_mie = 0; ext_irq = 0;
        repeat (LAT + 4) step();

        // Withdraw on MIE drop, ack-wins-over-withdraw, withdraw on mie clear
        bus.mie = 32'h80; bus.mstatus_mie = 1; timer_irq = 1;
        wait_req("wd_req_seen");
        bus.mstatus_mie = 0; step();
        chk("wd_drop", 32'(bus.irq_req), 32'd0);
        bus.mstatus_mie = 1; step();
        chk("wd_idle_rereq", 32'(bus.irq_req), 32'd1);
        chk("wd_cause", bus.irq_cause, 32'h8000_0007);
        bus.irq_ack = 1; bus.mstatus_mie = 0; step();
        bus.irq_ack = 0;
        chk("ackwin_drop", 32'(bus.irq_req), 32'd0);
        bus.mstatus_mie = 1;
        repeat (2) begin
            step();
            chk("ackwin_wait", 32'(bus.irq_req), 32'd0);
        end
        bus.mstatus_mie = 0; step();
        bus.mstatus_mie = 1; step();
        chk("after_wait_rereq", 32'(bus.irq_req), 32'd1);
        bus.mie = '0; step();
        chk("mie_withdraw", 32'(bus.irq_req), 32'd0);

        // Reset while a request is outstanding
        bus.mie = 32'h80; step();
        chk("rst_pre_req", 32'(bus.irq_req), 32'd1);
        rst_n = 0;
        #1;
        chk("rst_mid_mip_in",    bus.mip_in,       32'h0);
        chk("rst_mid_wr_mip",    32'(bus.wr_mip),  32'h0);
        chk("rst_mid_irq_req",   32'(bus.irq_req), 32'h0);
        chk("rst_mid_irq_cause", bus.irq_cause,    32'h0);
        model_reset();
        timer_irq = 0; bus.mie = '0; bus.mstatus_mie = 0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        repeat (4) begin
            step();
            chk("rst_no_replay", 32'(bus.irq_req), 32'd0);
        end

        // Randomised traffic against the reference model
        bus.mie = 32'hFFF;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(7) == 0) ext_irq   = ~ext_irq;
            if ($urandom_range(7) == 0) timer_irq = ~timer_irq;
            if ($urandom_range(7) == 0) soft_irq  = ~soft_irq;
            bus.csr_mip_we    = ($urandom_range(7) == 0);
            bus.csr_mip_wdata = $urandom;
            if ($urandom_range(15) == 0) bus.mie = $urandom;
            if ($urandom_range(5) == 0)  bus.mstatus_mie = ~bus.mstatus_mie;
            bus.irq_ack = bus.irq_req && ($urandom_range(2) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
